rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the ROM word-address width (log2 of ROM depth).
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  SHALL flag a read request on port 0 (core fetch) or port 1 (loader/debug).
REQ-006 req0_addr / req1_addr  input  ADDR_W  SHALL carry the requested word address.
REQ-007 req0_ready / req1_ready  output  1  SHALL indicate the request is granted and accepted this cycle.
REQ-008 rsp0_valid / rsp1_valid  output  1  SHALL flag a valid response word held for that port.
REQ-009 rsp0_data / rsp1_data  output  DATA_W  SHALL carry the response word.
REQ-010 rsp0_ready / rsp1_ready  input  1  SHALL indicate the port consumes its response this cycle.
REQ-011 rom_addr_o  output  ADDR_W  SHALL drive the shared combinational ROM address.
REQ-012 rom_data_i  input  DATA_W  SHALL return the ROM word for rom_addr_o in the same cycle.
REQ-013 busy_o  output  1  SHALL be high when either rsp_valid is high.

Function
REQ-014 Port i SHALL be eligible when req_i_valid=1 and (rsp_i_valid=0 or rsp_i_ready=1).
REQ-015 At most one port SHALL be granted per cycle; req_i_ready SHALL be 1 only for the granted port, combinationally from current inputs and state.
REQ-016 Single eligible port SHALL be granted; no eligible port means no grant.
REQ-017 Both eligible: winner per Configuration section (REQ-027/028).
REQ-018 On grant, rom_addr_o SHALL equal the granted port's req_addr in that cycle.
REQ-019 No grant: rom_addr_o SHALL hold its last driven value.
REQ-020 Grant at edge N: rsp_i_data SHALL load rom_data_i and rsp_i_valid SHALL be 1 from edge N+1 (latency 1).
REQ-021 rsp_i_data SHALL stay stable while rsp_i_valid=1 and rsp_i_ready=0.
REQ-022 rsp_i_ready=1 with rsp_i_valid=1 and no new grant to port i: rsp_i_valid SHALL clear next edge.
REQ-023 Simultaneous consume and re-grant on port i: rsp_i_valid SHALL stay 1 and rsp_i_data take the new word (back-to-back, one word per cycle per port).
REQ-024 rsp_i_ready with rsp_i_valid=0 SHALL have no effect.
REQ-025 Port 1 activity SHALL never alter port 0 response registers, and vice versa.

Reset
REQ-026 rst=1 SHALL immediately clear rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rom_addr_o, last-grant pointer (=port 1, so port 0 wins first), and busy_o to 0/stated value; req_i_ready SHALL be 0 during reset; in-flight requests are discarded and no response issues for them after rst deasserts.

Configuration
REQ-027 With ROM_ARB_RR_EN defined: both eligible SHALL grant the port not granted last; pointer SHALL update on every grant.
REQ-028 Without ROM_ARB_RR_EN: both eligible SHALL always grant port 0; no pointer register SHALL exist.

Verification
REQ-029 Reset then port 0 only, addr 0x00..0x03 back-to-back, rsp0_ready=1 -> req0_ready=1 each cycle; rsp0_data = ROM[0..3] one cycle after each grant; rsp1_valid stays 0.
REQ-030 Both ports request continuously (port0 addr 0x10, port1 addr 0x20), both rsp_ready=1, ROM_ARB_RR_EN defined -> grants alternate 0,1,0,1 starting port 0; each port one word every 2 cycles.
REQ-031 Same stimulus as REQ-030 without ROM_ARB_RR_EN -> port 0 granted every cycle; req1_ready stays 0.
REQ-032 Port 0 granted addr 0x05, rsp0_ready=0 for 3 cycles while req0_valid=1 -> req0_ready=0 for those cycles, rsp0_data = ROM[5] stable; port 1 granted meanwhile; after rsp0_ready=1 port 0 regranted same cycle.
REQ-033 Assert rst for one cycle mid-stream with both rsp_valid=1 -> both rsp_valid 0 immediately; rom_addr_o=0; first grant after reset goes to port 0 when both request.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Two-port ROM read bundle: requests and held responses for
// port 0 (core fetch) and port 1 (loader/debug).
interface rom_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_ready;

  modport master (
    output req0_valid, req0_addr, rsp0_ready,
    output req1_valid, req1_addr, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_addr, rsp0_ready,
    input  req1_valid, req1_addr, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM.
// Define ROM_ARB_RR_EN for round-robin on contention (else port 0 wins).
module rom_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  rom_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              busy_o
);

  logic              el0, el1;
  logic              gnt0, gnt1;

  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  // A port may take a new word when its holding slot is empty or draining
  assign el0 = ~rst & bus.req0_valid &
               (~rsp0_valid_q | bus.rsp0_ready);
  assign el1 = ~rst & bus.req1_valid &
               (~rsp1_valid_q | bus.rsp1_ready);

`ifdef ROM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    gnt0   = el0 & (~el1 | last_q);
    gnt1   = el1 & ~gnt0;
    last_d = last_q;
    if (gnt0) last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;
  end

  // Pointer resets to port 1 so port 0 wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    gnt0 = el0;
    gnt1 = el1 & ~el0;
  end
`endif

  always_comb begin
    rom_addr_o = rom_addr_q;
    unique case (1'b1)
      gnt0:    rom_addr_o = bus.req0_addr;
      gnt1:    rom_addr_o = bus.req1_addr;
      default: rom_addr_o = rom_addr_q;
    endcase
    rom_addr_d = rom_addr_o;
  end

  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    if (gnt0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = rom_data_i;
    end else if (bus.rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    if (gnt1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = rom_data_i;
    end else if (bus.rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rom_addr_q   <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rom_addr_q   <= rom_addr_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign busy_o         = rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: expected ROM words queued at
// grant time, popped when the port consumes its response.
module tb_rom_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;

  rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(logic [AW-1:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  int errs = 0;
  int checks = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  task automatic check_eq(string tag, logic [63:0] got,
                          logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        if (q0.size() == 0)
          check_eq("rsp0_spurious", bus.rsp0_valid, 0);
        else
          check_eq("rsp0_data", bus.rsp0_data, q0.pop_front());
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        if (q1.size() == 0)
          check_eq("rsp1_spurious", bus.rsp1_valid, 0);
        else
          check_eq("rsp1_data", bus.rsp1_data, q1.pop_front());
      end
    end
  end

  task automatic cyc(logic v0, logic [AW-1:0] a0, logic r0,
                     logic v1, logic [AW-1:0] a1, logic r1,
                     logic e0, logic e1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.rsp0_ready = r0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.rsp1_ready = r1;
    @(negedge clk);
    check_eq("req0_ready", bus.req0_ready, e0);
    check_eq("req1_ready", bus.req1_ready, e1);
    if (e0) begin
      check_eq("rom_addr0", rom_addr, a0);
      q0.push_back(rom_word(a0));
    end
    if (e1) begin
      check_eq("rom_addr1", rom_addr, a1);
      q1.push_back(rom_word(a1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_rsp0_valid", bus.rsp0_valid, 0);
    check_eq("rst_rsp1_valid", bus.rsp1_valid, 0);
    check_eq("rst_rsp0_data", bus.rsp0_data, 0);
    check_eq("rst_rsp1_data", bus.rsp1_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_req0_ready", bus.req0_ready, 0);
    check_eq("rst_req1_ready", bus.req1_ready, 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 8'h07;
    bus.rsp0_ready = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 8'h09;
    bus.rsp1_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // port 0 alone, back-to-back
    for (int i = 0; i < 4; i++) begin
      cyc(1, AW'(i), 1, 0, 0, 1, 1, 0);
      check_eq("t1_rsp1_valid", bus.rsp1_valid, 0);
      check_eq("t1_busy", busy, 1);
    end
    cyc(0, 0, 1, 0, 0, 1, 0, 0);
    check_eq("t1_hold_addr", rom_addr, 8'h03);
    check_eq("t1_drained", bus.rsp0_valid, 0);
    check_eq("t1_idle_busy", busy, 0);

    // both ports contend continuously
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (RR)
        cyc(1, 8'h10, 1, 1, 8'h20, 1, (k % 2) == 0, (k % 2) == 1);
      else
        cyc(1, 8'h10, 1, 1, 8'h20, 1, 1, 0);
    end
    cyc(0, 0, 1, 0, 0, 1, 0, 0);

    // port 0 stalls its response, port 1 proceeds
    cyc(1, 8'h05, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 8'h05, 0, 1, 8'h30, 1, 0, 1);
      check_eq("t3_rsp0_valid", bus.rsp0_valid, 1);
      check_eq("t3_rsp0_stable", bus.rsp0_data, rom_word(8'h05));
    end
    cyc(1, 8'h05, 1, 1, 8'h30, 1, 1, 0);
    cyc(0, 0, 1, 0, 0, 1, 0, 0);

    // both responses held, reset mid-stream
    cyc(1, 8'h40, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 8'h41, 0, 0, 1);
    check_eq("t4_rsp0_held", bus.rsp0_valid, 1);
    check_eq("t4_rsp1_held", bus.rsp1_valid, 1);
    check_eq("t4_busy", busy, 1);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #2;
    do_reset();
    cyc(1, 8'h50, 1, 1, 8'h60, 1, 1, 0);
    if (RR)
      cyc(1, 8'h50, 1, 1, 8'h60, 1, 0, 1);
    else
      cyc(1, 8'h50, 1, 1, 8'h60, 1, 1, 0);
    cyc(0, 0, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0, 0);

    check_eq("q0_empty", q0.size(), 0);
    check_eq("q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
